// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM encoding, byte width and an index-width helper.
package uart_tx_arb_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Request and transmitter bundle shared by the arbiter and its users.
// master drives requests and tx_busy; slave is the arbiter side.
interface uart_tx_arb_if
   import uart_tx_arb_pkg::*;
#(
   parameter int N = 4
);

   logic [N-1:0]        req_valid;
   logic [N*BYTE_W-1:0] req_data;
   logic [N-1:0]        req_lock;
   logic [N-1:0]        req_ready;
   logic [BYTE_W-1:0]   tx_data;
   logic                tx_start;
   logic                tx_busy;

   modport master (
      output req_valid, req_data, req_lock, tx_busy,
      input  req_ready, tx_data, tx_start
   );

   modport slave (
      input  req_valid, req_data, req_lock, tx_busy,
      output req_ready, tx_data, tx_start
   );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above
// ptr, wrapping to index 0. Reusable by other byte arbiters.
module uart_tx_arb_rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]        req,
   input  logic [idx_w(N)-1:0] ptr,
   output logic [idx_w(N)-1:0] idx,
   output logic                any
);

   localparam int W = idx_w(N);

   logic [N-1:0] rot;

   // Rotate so ptr sits at bit 0, then keep the lowest set bit.
   always_comb begin
      rot = N'({req, req} >> ptr);
      idx = '0;
      any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            idx = W'((int'(ptr) + k) % N);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter among N byte requesters with
// round-robin grants, message locking and a busy-rise timeout.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int BUSY_TO = 15
) (
   input  logic                clk,
   input  logic                rst,
   uart_tx_arb_if.slave        bus,
   output logic [idx_w(N)-1:0] grant_id,
   output logic                active,
   output logic                err
);

   localparam int W  = idx_w(N);
   localparam int CW = idx_w(BUSY_TO + 1);

   state_t        state;
   state_t        state_nx;
   logic [W-1:0]  ptr;
   logic [W-1:0]  last;
   logic [W-1:0]  pick_idx;
   logic [W-1:0]  win;
   logic [CW-1:0] cnt;
   logic          pick_any;
   logic          locked;
   logic          grant;
   logic          timeout;

   uart_tx_arb_rr_pick #(.N(N)) u_pick (
      .req (bus.req_valid),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Winner selection; a held lock on the last winner overrides RR.
   always_comb begin
      locked  = bus.req_lock[last] & bus.req_valid[last];
      win     = locked ? last : pick_idx;
      grant   = (state == IDLE) & ~bus.tx_busy & pick_any;
      timeout = (state == WAIT_BUSY) & ~bus.tx_busy
              & (cnt == CW'(BUSY_TO - 1));
   end

   // Next-state logic for the grant / busy tracking sequence.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (grant) state_nx = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.tx_busy)  state_nx = WAIT_DONE;
            else if (timeout) state_nx = IDLE;
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Registered outputs, RR pointer, lock owner and timeout count.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr           <= '0;
         last          <= '0;
         grant_id      <= '0;
         cnt           <= '0;
         bus.tx_data   <= '0;
         bus.req_ready <= '0;
         bus.tx_start  <= 1'b0;
         active        <= 1'b0;
         err           <= 1'b0;
      end else begin
         bus.req_ready <= '0;
         bus.tx_start  <= 1'b0;
         err           <= timeout;
         active        <= (state_nx != IDLE);
         if (grant) begin
            bus.req_ready <= N'(1) << win;
            bus.tx_start  <= 1'b1;
            bus.tx_data   <= bus.req_data[win*BYTE_W +: BYTE_W];
            grant_id      <= win;
            last          <= win;
            ptr           <= (win == W'(N - 1)) ? '0 : win + 1'b1;
            cnt           <= '0;
         end else if (state == WAIT_BUSY && !bus.tx_busy) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus a
// randomized run against a transaction-level arbitration model.
module tb_uart_tx_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant_id;
   logic       active;
   logic       err;

   uart_tx_arb_if #(.N(4)) bus ();

   uart_tx_arb #(.N(4), .BUSY_TO(15)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .grant_id (grant_id),
      .active   (active),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy rises the cycle after start.
   int   busy_cnt  = 0;
   int   frame_len = 4;
   logic ignore    = 1'b0;

   assign bus.tx_busy = (busy_cnt != 0);

   always @(posedge clk) begin
      if (bus.tx_start && !ignore) busy_cnt <= frame_len;
      else if (busy_cnt > 0)       busy_cnt <= busy_cnt - 1;
   end

   // Requesters: queues of {lock, data}.
   logic [8:0] q [4][$];
   logic [3:0] present = 4'hF;

   int n_vec = 0;
   int n_bad = 0;
   int n_start = 0;
   int cyc = 0;
   int last_start = 0;
   int m_ptr = 0;
   int m_last = 0;
   logic [7:0] held = 8'h00;
   int seen [$];
   int seen_d [$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] v,
                               input logic [3:0] l);
      if (l[m_last] && v[m_last]) return m_last;
      for (int k = 0; k < 4; k++)
         if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      return -1;
   endfunction

   task automatic drive();
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < 4; i++) begin
         if (q[i].size() > 0 && present[i]) begin
            v[i]       = 1'b1;
            l[i]       = q[i][0][8];
            d[8*i +: 8] = q[i][0][7:0];
         end
      end
      bus.req_valid = v;
      bus.req_lock  = l;
      bus.req_data  = d;
   endtask

   task automatic check_cycle();
      int         w;
      logic [8:0] e;
      cyc++;
      chk("ready_vs_start", {31'b0, |bus.req_ready},
          {31'b0, bus.tx_start});
      if (bus.tx_start) begin
         w = pick(bus.req_valid, bus.req_lock);
         chk("start_had_valid", {31'b0, w >= 0}, 1);
         if (w >= 0) begin
            e = q[w][0];
            chk("grant_ready", bus.req_ready, 32'(1) << w);
            chk("grant_id", grant_id, w);
            chk("grant_data", bus.tx_data, e[7:0]);
            held   = e[7:0];
            m_last = w;
            m_ptr  = (w + 1) % 4;
            seen.push_back(w);
            seen_d.push_back(int'(e[7:0]));
         end
         if (n_start > 0)
            chk("start_spacing", {31'b0, (cyc - last_start) >= 3}, 1);
         last_start = cyc;
         n_start++;
      end else if (active) begin
         chk("tx_data_hold", bus.tx_data, held);
      end
      if (err) chk("err_delay", cyc - last_start, 15);
      for (int i = 0; i < 4; i++)
         if (bus.req_ready[i] && q[i].size() > 0)
            void'(q[i].pop_front());
      drive();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_cycle();
   endtask

   task automatic wait_starts(input int n, input int budget,
                              input string tag);
      int k = 0;
      while (n_start < n && k < budget) begin
         step();
         k++;
      end
      chk(tag, {31'b0, n_start >= n}, 1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (active && k < budget) begin
         step();
         k++;
      end
      chk(tag, active, 0);
   endtask

   initial begin
      int exp_rr [5]   = '{0, 1, 2, 3, 0};
      int exp_lk [5]   = '{1, 1, 1, 3, 0};
      int exp_lkd [5]  = '{'h11, 'h22, 'h33, 'h3B, 'h0A};
      int s0;
      int k;
      int total;
      logic empty;

      rst = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_start", bus.tx_start, 0);
      chk("rst_active", active, 0);
      chk("rst_err", err, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      rst = 1'b0;

      // All four valid, no lock.
      seen.delete();
      s0 = n_start;
      q[0].push_back(9'h010);
      q[0].push_back(9'h014);
      q[1].push_back(9'h011);
      q[2].push_back(9'h012);
      q[3].push_back(9'h013);
      drive();
      wait_starts(s0 + 5, 200, "rr_starts");
      wait_idle(50, "rr_idle");
      chk("rr_count", n_start - s0, 5);
      for (int i = 0; i < 5; i++)
         if (i < seen.size()) chk("rr_order", seen[i], exp_rr[i]);

      // Lock keeps requester 1 for three bytes.
      seen.delete();
      seen_d.delete();
      s0 = n_start;
      q[1].push_back(9'h111);
      q[1].push_back(9'h122);
      q[1].push_back(9'h133);
      q[0].push_back(9'h00A);
      q[3].push_back(9'h03B);
      drive();
      wait_starts(s0 + 5, 200, "lock_starts");
      wait_idle(50, "lock_idle");
      for (int i = 0; i < 5; i++) begin
         if (i < seen.size()) begin
            chk("lock_order", seen[i], exp_lk[i]);
            chk("lock_data", seen_d[i], exp_lkd[i]);
         end
      end

      // Single requester, 20-cycle frame.
      frame_len = 20;
      s0 = n_start;
      q[2].push_back(9'h0A5);
      drive();
      wait_starts(s0 + 1, 20, "single_start");
      chk("single_ready", bus.req_ready, 4'b0100);
      chk("single_data", bus.tx_data, 8'hA5);
      chk("single_gid", grant_id, 2);
      k = 0;
      while (active && k < 100) begin
         step();
         k++;
      end
      chk("single_active_len", k, 22);

      // Transmitter ignores start: timeout then next requester.
      frame_len = 4;
      ignore = 1'b1;
      s0 = n_start;
      q[3].push_back(9'h0C3);
      q[0].push_back(9'h0C0);
      drive();
      wait_starts(s0 + 1, 20, "to_start");
      chk("to_first", seen[$], 3);
      k = 0;
      while (!err && k < 40) begin
         step();
         k++;
      end
      chk("to_delay", k, 15);
      ignore = 1'b0;
      step();
      chk("to_regrant", bus.tx_start, 1);
      chk("to_err_pulse", err, 0);
      chk("to_next", seen[$], 0);
      wait_idle(50, "to_idle");

      // Reset mid-frame, then busy gating.
      frame_len = 30;
      s0 = n_start;
      q[1].push_back(9'h0D1);
      drive();
      wait_starts(s0 + 1, 20, "rs_start");
      repeat (4) step();
      chk("rs_in_frame", {31'b0, active & bus.tx_busy}, 1);
      rst = 1'b1;
      step();
      chk("rs_ready", bus.req_ready, 0);
      chk("rs_start0", bus.tx_start, 0);
      chk("rs_active", active, 0);
      chk("rs_err", err, 0);
      chk("rs_gid", grant_id, 0);
      chk("rs_data", bus.tx_data, 0);
      m_ptr  = 0;
      m_last = 0;
      rst = 1'b0;
      frame_len = 4;
      q[0].push_back(9'h0E0);
      q[2].push_back(9'h0E2);
      drive();
      s0 = n_start;
      k = 0;
      while (bus.tx_busy && k < 60) begin
         step();
         chk("rs_busy_gate", bus.tx_start, 0);
         k++;
      end
      wait_starts(s0 + 1, 10, "rs_regrant");
      chk("rs_first", seen[$], 0);
      wait_starts(s0 + 2, 40, "rs_second");
      wait_idle(50, "rs_idle");

      // Randomized traffic against the model.
      total = 0;
      for (int i = 0; i < 4; i++) begin
         int n = $urandom_range(5, 25);
         for (int j = 0; j < n; j++) begin
            logic [8:0] e;
            e[7:0] = 8'($urandom);
            e[8]   = ($urandom_range(0, 3) == 0);
            q[i].push_back(e);
         end
         total += n;
      end
      s0 = n_start;
      k = 0;
      empty = 1'b0;
      while (!(empty && !active) && k < 20000) begin
         frame_len = $urandom_range(1, 6);
         ignore    = ($urandom_range(0, 9) == 0);
         present   = 4'($urandom);
         drive();
         step();
         empty = (q[0].size() + q[1].size() + q[2].size()
                + q[3].size()) == 0;
         k++;
      end
      chk("rand_drained", {31'b0, empty}, 1);
      chk("rand_count", n_start - s0, total);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
